// File: rtl/reader_byte_serializer_if.sv
// Handshake bundle for reader_byte_serializer: burst control, reader FIFO port and byte stream.
// master = serializer side, slave = environment (burst controller, FIFO, byte checkers).
interface reader_byte_serializer_if #(
    parameter int unsigned NUM_WORDS_W = 16
);
    // Burst control
    logic                   i_start;
    logic [NUM_WORDS_W-1:0] i_num_words;
    logic                   i_abort;
    logic                   o_busy;
    logic                   o_done;

    // Reader FIFO
    logic                   i_fifo_empty;
    logic                   o_fifo_rd_en;
    logic [31:0]            i_fifo_rdata;

    // Byte stream
    logic [7:0]             o_serialized_output;
    logic                   o_serialized_output_valid;
    logic [1:0]             o_serialize_counter;
    logic                   i_out_ready;

    modport master (
        input  i_start,
        input  i_num_words,
        input  i_abort,
        output o_busy,
        output o_done,
        input  i_fifo_empty,
        output o_fifo_rd_en,
        input  i_fifo_rdata,
        output o_serialized_output,
        output o_serialized_output_valid,
        output o_serialize_counter,
        input  i_out_ready
    );

    modport slave (
        output i_start,
        output i_num_words,
        output i_abort,
        input  o_busy,
        input  o_done,
        output i_fifo_empty,
        input  o_fifo_rd_en,
        output i_fifo_rdata,
        input  o_serialized_output,
        input  o_serialized_output_valid,
        input  o_serialize_counter,
        output i_out_ready
    );
endinterface

// File: rtl/reader_byte_serializer.sv
// Pops 32-bit words from the reader FIFO and streams them out LSB-first, one byte per beat.
// Optional word prefetch (zero-bubble word transitions) enabled by READER_SERIALIZER_PREFETCH_EN.
module reader_byte_serializer #(
    parameter int unsigned NUM_WORDS_W = 16
) (
    input logic                     CLK,
    input logic                     RESETn,
    reader_byte_serializer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StShift,
        StDone
    } state_e;

    state_e                 state_q;
    logic [NUM_WORDS_W-1:0] remaining_q;
    logic [31:0]            word_q;
    logic [1:0]             lane_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;

`ifdef READER_SERIALIZER_PREFETCH_EN
    logic [31:0]            pf_word_q;
    logic                   pf_valid_q;
    logic                   pf_pending_q;  // rd_en issued last cycle, data on i_fifo_rdata now
`endif

    logic accept;
    logic have_words;
    logic last_lane;
    logic req_pop;
    logic pf_pop;
    logic rd_en;

    assign accept     = valid_q & bus.i_out_ready;
    assign have_words = (remaining_q != '0);
    assign last_lane  = (lane_q == 2'd3);

    // Pop strobe is combinational; abort suppresses it so a cancelled burst never pops a word.
    always_comb begin
        req_pop = (state_q == StReq) && have_words && !bus.i_fifo_empty && !bus.i_abort;
        pf_pop  = 1'b0;
`ifdef READER_SERIALIZER_PREFETCH_EN
        pf_pop  = (state_q == StShift) && accept && (lane_q == 2'd2) && have_words &&
                  !bus.i_fifo_empty && !pf_valid_q && !pf_pending_q && !bus.i_abort;
`endif
        rd_en   = req_pop | pf_pop;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef READER_SERIALIZER_PREFETCH_EN
            pf_word_q    <= '0;
            pf_valid_q   <= 1'b0;
            pf_pending_q <= 1'b0;
`endif
        end else if (bus.i_abort) begin
            state_q      <= StIdle;
            lane_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef READER_SERIALIZER_PREFETCH_EN
            pf_valid_q   <= 1'b0;
            pf_pending_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (rd_en) begin
                remaining_q <= remaining_q - NUM_WORDS_W'(1);
            end
`ifdef READER_SERIALIZER_PREFETCH_EN
            pf_pending_q <= pf_pop;
`endif
            case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        remaining_q <= bus.i_num_words;
                        busy_q      <= 1'b1;
                        if (bus.i_num_words == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (req_pop) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    word_q  <= bus.i_fifo_rdata;
                    lane_q  <= '0;
                    valid_q <= 1'b1;
                    state_q <= StShift;
                end
                StShift: begin
                    if (accept) begin
                        if (!last_lane) begin
                            lane_q <= lane_q + 2'd1;
`ifdef READER_SERIALIZER_PREFETCH_EN
                        end else if (pf_pending_q) begin
                            word_q <= bus.i_fifo_rdata;
                            lane_q <= '0;
                        end else if (pf_valid_q) begin
                            word_q     <= pf_word_q;
                            pf_valid_q <= 1'b0;
                            lane_q     <= '0;
`endif
                        end else begin
                            valid_q <= 1'b0;
                            lane_q  <= '0;
                            if (have_words) begin
                                state_q <= StReq;
                            end else begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
                        end
                    end
`ifdef READER_SERIALIZER_PREFETCH_EN
                    // Fetched word not consumed straight away: park it in the prefetch buffer.
                    if (pf_pending_q && !(accept && last_lane)) begin
                        pf_word_q  <= bus.i_fifo_rdata;
                        pf_valid_q <= 1'b1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_fifo_rd_en              = rd_en;
    assign bus.o_busy                    = busy_q;
    assign bus.o_done                    = done_q;
    assign bus.o_serialized_output_valid = valid_q;
    assign bus.o_serialized_output       = word_q[{lane_q, 3'b000} +: 8];
    assign bus.o_serialize_counter       = lane_q;

endmodule

// File: tb/tb_reader_byte_serializer.sv
// Directed self-checking bench for reader_byte_serializer with a small reader-FIFO model.
// Expected word-gap timing follows READER_SERIALIZER_PREFETCH_EN when the bench is built with it.
module tb_reader_byte_serializer;

    localparam int unsigned NW = 16;
`ifdef READER_SERIALIZER_PREFETCH_EN
    localparam int unsigned GAP = 1;
`else
    localparam int unsigned GAP = 3;
`endif

    logic CLK;
    logic RESETn;

    reader_byte_serializer_if #(.NUM_WORDS_W(NW)) bus ();

    reader_byte_serializer #(.NUM_WORDS_W(NW)) dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reader FIFO model: data appears on i_fifo_rdata the cycle after the pop.
    logic [31:0] fifo_mem [16];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        force_empty;

    assign bus.i_fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (bus.o_fifo_rd_en) begin
            bus.i_fifo_rdata <= fifo_mem[rd_ptr[3:0]];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge.
    logic [7:0]  beat_byte [$];
    logic [1:0]  beat_lane [$];
    int unsigned beat_cyc  [$];
    int unsigned rd_cnt = 0, done_cnt = 0, valid_cnt = 0, stall_err = 0, empty_rd_err = 0;
    int unsigned last_rd_cyc = 0, last_done_cyc = 0;

    initial begin
        logic       prev_stall;
        logic [7:0] prev_byte;
        logic [1:0] prev_lane;
        prev_stall = 1'b0;
        prev_byte  = '0;
        prev_lane  = '0;
        forever begin
            @(negedge CLK);
            if (!RESETn) begin
                prev_stall = 1'b0;
            end else begin
                if (bus.o_fifo_rd_en) begin
                    rd_cnt++;
                    last_rd_cyc = cyc;
                    if (bus.i_fifo_empty) empty_rd_err++;
                end
                if (bus.o_done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (prev_stall && (!bus.o_serialized_output_valid ||
                    bus.o_serialized_output != prev_byte || bus.o_serialize_counter != prev_lane))
                    stall_err++;
                if (bus.o_serialized_output_valid) begin
                    valid_cnt++;
                    if (bus.i_out_ready && !bus.i_abort) begin
                        beat_byte.push_back(bus.o_serialized_output);
                        beat_lane.push_back(bus.o_serialize_counter);
                        beat_cyc.push_back(cyc);
                    end
                end
                prev_stall = bus.o_serialized_output_valid && !bus.i_out_ready && !bus.i_abort;
                prev_byte  = bus.o_serialized_output;
                prev_lane  = bus.o_serialize_counter;
            end
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_words [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_ptr[3:0]] = w;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Returns the cycle stamp of cycle 1 (the cycle after the start edge).
    task automatic start_burst(input int unsigned n, output int unsigned t0);
        bus.i_num_words = n[NW-1:0];
        bus.i_start     = 1'b1;
        tick();
        t0          = cyc;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input bit toggle, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (bus.o_busy && n < budget) begin
            tick();
            if (toggle) bus.i_out_ready = ~bus.i_out_ready;
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_burst(input string tag, input int unsigned b0, input int unsigned t0,
                               input int unsigned n, input int unsigned gap);
        logic [31:0] w;
        check({tag, "_beats"}, beat_byte.size() - b0, 4 * n);
        for (int i = 0; i < int'(4 * n); i++) begin
            w = exp_words[i / 4];
            check({tag, "_byte"}, 32'(beat_byte[b0 + i]), 32'(w[8 * (i % 4) +: 8]));
            check({tag, "_lane"}, 32'(beat_lane[b0 + i]), i % 4);
            if (gap != 0)
                check({tag, "_cyc"}, beat_cyc[b0 + i] - t0 + 1, 3 + i + (i / 4) * (gap - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, b0, r0, d0, v0, s0, e0, n;

        RESETn          = 1'b0;
        bus.i_start     = 1'b0;
        bus.i_num_words = '0;
        bus.i_abort     = 1'b0;
        bus.i_out_ready = 1'b1;
        force_empty     = 1'b0;
        repeat (2) tick();
        check("rst_busy",  32'(bus.o_busy), 0);
        check("rst_done",  32'(bus.o_done), 0);
        check("rst_valid", 32'(bus.o_serialized_output_valid), 0);
        check("rst_rd_en", 32'(bus.o_fifo_rd_en), 0);
        check("rst_byte",  32'(bus.o_serialized_output), 0);
        check("rst_cnt",   32'(bus.o_serialize_counter), 0);
        RESETn = 1'b1;
        tick();

        // One word; a start pulse mid-burst must be ignored. The extra FIFO word feeds the next burst.
        push(32'h44332211);
        push(32'hA3A2A1A0);
        exp_words[0] = 32'h44332211;
        b0 = beat_byte.size(); r0 = rd_cnt; d0 = done_cnt;
        start_burst(1, t0);
        tick(); tick();
        bus.i_num_words = 16'd5;
        bus.i_start     = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_idle("one", 1'b0, 50);
        check_burst("one", b0, t0, 1, GAP);
        check("one_rd",     rd_cnt - r0, 1);
        check("one_done",   done_cnt - d0, 1);
        check("one_done_t", last_done_cyc - t0 + 1, 7);
        repeat (3) tick();
        check("one_no_restart", 32'(bus.o_busy), 0);
        check("one_rd_after",   rd_cnt - r0, 1);

        // Three words, ready held high.
        push(32'hB3B2B1B0);
        push(32'hC3C2C1C0);
        exp_words[0] = 32'hA3A2A1A0; exp_words[1] = 32'hB3B2B1B0; exp_words[2] = 32'hC3C2C1C0;
        b0 = beat_byte.size(); r0 = rd_cnt; d0 = done_cnt;
        start_burst(3, t0);
        wait_idle("three", 1'b0, 80);
        check_burst("three", b0, t0, 3, GAP);
        check("three_rd",     rd_cnt - r0, 3);
        check("three_done",   done_cnt - d0, 1);
        check("three_done_t", last_done_cyc - t0 + 1, 3 + 12 + 2 * (GAP - 1));

        // Two words with ready toggling every cycle.
        push(32'hDDCCBBAA);
        push(32'h04030201);
        exp_words[0] = 32'hDDCCBBAA; exp_words[1] = 32'h04030201;
        b0 = beat_byte.size(); r0 = rd_cnt; d0 = done_cnt; s0 = stall_err;
        bus.i_out_ready = 1'b0;
        start_burst(2, t0);
        wait_idle("toggle", 1'b1, 80);
        bus.i_out_ready = 1'b1;
        check_burst("toggle", b0, t0, 2, 0);
        check("toggle_stall", stall_err - s0, 0);
        check("toggle_rd",    rd_cnt - r0, 2);
        check("toggle_done",  done_cnt - d0, 1);

        // FIFO empty for the first five REQ cycles.
        push(32'h0F0E0D0C);
        exp_words[0] = 32'h0F0E0D0C;
        b0 = beat_byte.size(); r0 = rd_cnt; e0 = empty_rd_err;
        force_empty = 1'b1;
        start_burst(1, t0);
        repeat (5) tick();
        force_empty = 1'b0;
        wait_idle("empty", 1'b0, 50);
        check_burst("empty", b0, t0, 1, 0);
        check("empty_rd",     rd_cnt - r0, 1);
        check("empty_rd_t",   last_rd_cyc - t0 + 1, 6);
        check("empty_rd_err", empty_rd_err - e0, 0);
        check("empty_done_t", last_done_cyc - t0 + 1, 12);

        // Zero-word burst.
        b0 = beat_byte.size(); r0 = rd_cnt; d0 = done_cnt; v0 = valid_cnt;
        start_burst(0, t0);
        wait_idle("zero", 1'b0, 20);
        check("zero_done",   done_cnt - d0, 1);
        check("zero_done_t", last_done_cyc - t0 + 1, 1);
        check("zero_rd",     rd_cnt - r0, 0);
        check("zero_valid",  valid_cnt - v0, 0);

        // Abort while lane 1 of the second word is presented.
        push(32'h13121110);
        push(32'h23222120);
        push(32'h33323130);
        b0 = beat_byte.size(); r0 = rd_cnt; d0 = done_cnt;
        start_burst(3, t0);
        n = 0;
        while (!(bus.o_serialized_output_valid && bus.o_serialize_counter == 2'd1 &&
                 beat_byte.size() - b0 == 5) && n < 40) begin
            tick();
            n++;
        end
        check("abort_reach", 32'(n < 40), 1);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        check("abort_busy",  32'(bus.o_busy), 0);
        check("abort_valid", 32'(bus.o_serialized_output_valid), 0);
        repeat (3) tick();
        check("abort_done", done_cnt - d0, 0);
        check("abort_rd",   rd_cnt - r0, 2);
        check("abort_idle", 32'(bus.o_busy), 0);

        // Next burst picks up the word left in the FIFO.
        exp_words[0] = 32'h33323130;
        b0 = beat_byte.size();
        start_burst(1, t0);
        wait_idle("post_abort", 1'b0, 50);
        check_burst("post_abort", b0, t0, 1, GAP);
        check("post_abort_done_t", last_done_cyc - t0 + 1, 7);

        // Asynchronous reset in the middle of SHIFT.
        push(32'h5A5B5C5D);
        start_burst(1, t0);
        n = 0;
        while (!(bus.o_serialized_output_valid && bus.o_serialize_counter == 2'd2) && n < 20) begin
            tick();
            n++;
        end
        check("mid_rst_reach", 32'(n < 20), 1);
        #2;
        RESETn = 1'b0;
        #1;
        check("mid_rst_busy",  32'(bus.o_busy), 0);
        check("mid_rst_valid", 32'(bus.o_serialized_output_valid), 0);
        check("mid_rst_byte",  32'(bus.o_serialized_output), 0);
        check("mid_rst_cnt",   32'(bus.o_serialize_counter), 0);
        check("mid_rst_rd_en", 32'(bus.o_fifo_rd_en), 0);
        @(negedge CLK);
        RESETn = 1'b1;
        tick();

        push(32'h99887766);
        exp_words[0] = 32'h99887766;
        b0 = beat_byte.size(); d0 = done_cnt;
        start_burst(1, t0);
        wait_idle("after_rst", 1'b0, 50);
        check_burst("after_rst", b0, t0, 1, GAP);
        check("after_rst_done",   done_cnt - d0, 1);
        check("after_rst_done_t", last_done_cyc - t0 + 1, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
